pat_seq_det: RTL and testbench
==============================

# pat_seq_det

Parametrised serial pattern detector with an integrated hit counter and threshold flag. It is the next generation of the fixed "1001" detector, counter and decoder chain. It adds a runtime-loadable pattern of configurable length, overlap/non-overlap mode, bit-valid qualification, a saturating hit counter and a programmable threshold. It sits on a serial bit stream and flags each pattern match (Z1) and the Nth match (Z2).

## Interface
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PAT_RST, 4'b1001, pattern register value after reset; width PAT_LEN.
- CNT_W, 3, hit counter width.
- THR, 3, match count that asserts Z2; legal range 1..2^CNT_W-1.
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- X  in  1  serial data bit.
- X_VLD  in  1  X is sampled only when high.
- PAT  in  PAT_LEN  new pattern; MSB is the first bit received.
- PAT_LD  in  1  loads PAT into the pattern register and restarts detection.
- OVL  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- CLR  in  1  clears the hit counter and Z2.
- Z1  out  1  registered one-cycle match pulse.
- Z2  out  1  registered threshold flag.
- CNT  out  CNT_W  registered hit count.

## Operation
- Registers: PAT_R (PAT_LEN), HIST (PAT_LEN), FILL (0..PAT_LEN), CNT, Z1, Z2.
- Detector states are derived from FILL:
  - FILLING: FILL < PAT_LEN.
  - ARMED: FILL == PAT_LEN.
- Accepted bit (X_VLD=1, PAT_LD=0):
  - HIST <= {HIST[PAT_LEN-2:0], X}.
  - FILL increments, saturating at PAT_LEN.
- Match (combinational): accepted bit AND post-shift FILL == PAT_LEN AND {HIST[PAT_LEN-2:0], X} == PAT_R.
- On a match:
  - Z1 <= 1 for exactly one cycle.
  - OVL=1: FILL stays at PAT_LEN, so the history tail can start the next match.
  - OVL=0: FILL <= 0, so the next match needs PAT_LEN fresh bits.
- OVL is sampled on every accepted bit. Changing OVL does not flush the history.
- PAT_LD:
  - PAT_R <= PAT, FILL <= 0, Z1 <= 0.
  - A bit presented in the same cycle is dropped.
  - CNT and Z2 are unaffected.
- Counter:
  - Each match increments CNT, saturating at 2^CNT_W-1.
  - Z2 <= (next CNT >= THR).
- Priority:
  - Detector: RST > PAT_LD > accepted bit.
  - Counter: RST > CLR > auto-clear > match increment.
- CLR coincident with a match: CNT <= 0, Z2 <= 0, Z1 still pulses.
- X_VLD=0: all detector state holds and Z1 <= 0.
- Reset values: Z1=0, Z2=0, CNT=0, FILL=0, HIST=0, PAT_R=PAT_RST.

## Timing
- Match latency: Z1, CNT and Z2 all update on the same posedge that samples the final pattern bit. They are visible in the following cycle.
- Z1 is high for one cycle per match. Back-to-back Z1 is possible only with OVL=1 and a self-overlapping pattern, e.g. all-ones.
- RST, CLR and PAT_LD take effect at the posedge where they are sampled high.
- A reset mid-pattern discards any partial history. No Z1 is produced from pre-reset bits.
- After PAT_LD, the earliest Z1 is PAT_LEN accepted bits later.

## Configuration
- Macro: SEQDET_AUTO_CLR_EN.
- Defined:
  - When CNT == THR, the next posedge forces CNT <= 0 and Z2 <= 0, so Z2 is a one-cycle pulse per THR matches.
  - A match in that same cycle yields CNT <= 1.
  - The counter never saturates unless THR == 2^CNT_W-1.
- Undefined:
  - Z2 is sticky once CNT >= THR.
  - CNT saturates at 2^CNT_W-1.
  - Both hold until CLR or RST.

## Structure
- Shared package seq_det_pkg holds:
  - FILLING/ARMED encoding helpers.
  - Legal-range checks for PAT_LEN, CNT_W and THR.
  - Default constants PAT_RST_DEF and THR_DEF.
- One sub-module, hit_counter:
  - Inputs: CLK, RST, CLR, INC.
  - Outputs: CNT, Z2.
  - Parameters: CNT_W, THR.
  - Contains the SEQDET_AUTO_CLR_EN logic.
- The top level holds PAT_R, HIST, FILL and Z1.

## Test plan
- Reset, defaults, OVL=1, X_VLD=1, stream 1001001 -> Z1 pulses after bits 4 and 7; CNT=2; Z2=0.
- Same stream with OVL=0 -> single Z1 after bit 4; CNT=1.
- X_VLD gaps: bits 1,(gap),0,0,(gap,gap),1 -> exactly one Z1, in the cycle after the final accepted 1.
- PAT_LD with PAT=4'b0110 after 3 bits of 100, then 0110 -> no Z1 from the old history; Z1 after the 4th new bit.
- THR=3, three matches:
  - Z2=1 and CNT=3 on the same edge.
  - With SEQDET_AUTO_CLR_EN: next cycle CNT=0, Z2=0.
  - Without: a 4th match gives CNT=4 and Z2 stays 1.
- CNT_W=2, macro undefined:
  - 5 matches -> CNT holds at 3.
  - CLR coincident with a 6th match -> CNT=0, Z2=0, Z1=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: detector phase encoding,
// default constants and parameter legality helpers.
package seq_det_pkg;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_ARMED   = 1'b1
  } det_state_t;

  localparam int         PAT_LEN_DEF = 4;
  localparam logic [3:0] PAT_RST_DEF = 4'b1001;
  localparam int         CNT_W_DEF   = 3;
  localparam int         THR_DEF     = 3;

  // The detector is armed once the history holds a full pattern's worth of bits.
  function automatic det_state_t det_state(input int fill, input int pat_len);
    return (fill >= pat_len) ? ST_ARMED : ST_FILLING;
  endfunction

  function automatic bit pat_len_ok(input int n);
    return (n >= 2) && (n <= 16);
  endfunction

  function automatic bit cnt_w_ok(input int w);
    return (w >= 1) && (w <= 30);
  endfunction

  function automatic bit thr_ok(input int thr, input int w);
    return (thr >= 1) && (thr <= ((1 << w) - 1));
  endfunction

endpackage

// File: rtl/pat_seq_det_hit_counter.sv
// Saturating match counter with threshold flag Z2.
// Build option SEQDET_AUTO_CLR_EN turns Z2 into a one-cycle pulse per THR matches.
module hit_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int THR   = THR_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  output logic [CNT_W-1:0] CNT,
  output logic             Z2
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THR);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $error("hit_counter: CNT_W out of range");
  end
  if (!thr_ok(THR, CNT_W)) begin : g_bad_thr
    $error("hit_counter: THR out of range");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_z2;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_z2_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_z2_nxt  = r_z2;
    if (CLR) begin
      w_cnt_nxt = '0;
      w_z2_nxt  = 1'b0;
    end
`ifdef SEQDET_AUTO_CLR_EN
    // Reaching THR wraps the count; a match landing on the wrap counts as the first of the next batch.
    else if (r_cnt == THR_C) begin
      w_cnt_nxt = INC ? CNT_ONE : '0;
      w_z2_nxt  = INC && (THR_C == CNT_ONE);
    end
`endif
    else if (INC) begin
      w_cnt_nxt = w_cnt_inc;
      w_z2_nxt  = (w_cnt_inc >= THR_C);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_z2  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_z2  <= w_z2_nxt;
    end
  end

  assign CNT = r_cnt;
  assign Z2  = r_z2;

endmodule

// File: rtl/pat_seq_det.sv
// Serial pattern detector with runtime-loadable pattern, overlap control and hit counter.
// Build option SEQDET_AUTO_CLR_EN (inside hit_counter) selects auto-clearing threshold pulses.
//
// Handshake: a bit on X is consumed on a posedge only when X_VLD=1 and PAT_LD=0; there is no
// back-pressure, the detector accepts every qualified bit.
module pat_seq_det
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_RST_DEF),
  parameter int                 CNT_W   = CNT_W_DEF,
  parameter int                 THR     = THR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               X,
  input  logic               X_VLD,
  input  logic [PAT_LEN-1:0] PAT,
  input  logic               PAT_LD,
  input  logic               OVL,
  input  logic               CLR,
  output logic               Z1,
  output logic               Z2,
  output logic [CNT_W-1:0]   CNT
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
    $error("pat_seq_det: PAT_LEN out of range");
  end

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_z1;

  logic [PAT_LEN-1:0] w_pat_nxt;
  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_z1_nxt;
  logic               w_match;
  logic [PAT_LEN-1:0] w_shift;
  logic [FILL_W-1:0]  w_fill_inc;
  det_state_t         w_det_state;
  logic               w_unused_hist_msb;

  assign w_det_state = det_state(int'(r_fill), PAT_LEN);
  assign w_shift     = {r_hist[PAT_LEN-2:0], X};
  assign w_fill_inc  = (w_det_state == ST_ARMED) ? FILL_FULL : r_fill + FILL_ONE;
  // The oldest history bit only becomes visible in the register; matching uses the shifted view.
  assign w_unused_hist_msb = r_hist[PAT_LEN-1];

  always_comb begin
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_z1_nxt   = 1'b0;
    w_match    = 1'b0;
    if (PAT_LD) begin
      w_pat_nxt  = PAT;
      w_fill_nxt = '0;
    end else if (X_VLD) begin
      w_hist_nxt = w_shift;
      w_match    = (w_fill_inc == FILL_FULL) && (w_shift == r_pat);
      w_z1_nxt   = w_match;
      // Non-overlapping mode discards the matched bits so the next hit needs a fresh pattern.
      w_fill_nxt = (w_match && !OVL) ? '0 : w_fill_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pat  <= PAT_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_z1   <= 1'b0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_z1   <= w_z1_nxt;
    end
  end

  assign Z1 = r_z1;

  hit_counter #(
    .CNT_W (CNT_W),
    .THR   (THR)
  ) u_hit_counter (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (w_match),
    .CNT (CNT),
    .Z2  (Z2)
  );

endmodule

// File: tb/tb_pat_seq_det.sv
// Bench for pat_seq_det: two instances (CNT_W=3 and CNT_W=2) share one stimulus stream and
// are checked every cycle against a bit-queue reference model plus directed literal checks.
module tb_pat_seq_det;
  import seq_det_pkg::*;

  localparam int PAT_LEN = 4;
  localparam int THR     = 3;
  localparam int MAX_A   = 7;
  localparam int MAX_B   = 3;

  // clock / reset block
  logic clk;
  logic rst, x, x_vld, pat_ld, ovl, clr;
  logic [3:0] pat;
  logic z1_a, z2_a, z1_b, z2_b;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pat_seq_det u_dut_a (
    .CLK(clk), .RST(rst), .X(x), .X_VLD(x_vld), .PAT(pat), .PAT_LD(pat_ld),
    .OVL(ovl), .CLR(clr), .Z1(z1_a), .Z2(z2_a), .CNT(cnt_a)
  );

  pat_seq_det #(.CNT_W(2), .THR(3)) u_dut_b (
    .CLK(clk), .RST(rst), .X(x), .X_VLD(x_vld), .PAT(pat), .PAT_LD(pat_ld),
    .OVL(ovl), .CLR(clr), .Z1(z1_b), .Z2(z2_b), .CNT(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] z1_log;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: keep the last accepted bits since the last restart
  bit         m_bits[$];
  logic [3:0] m_pat;
  bit         m_z1, m_z2_a, m_z2_b, m_valid;
  int         m_cnt_a, m_cnt_b;

  task automatic cnt_model(inout int c, inout bit z, input int maxv, input bit inc, input bit cl);
    if (cl) begin
      c = 0;
      z = 0;
    end else begin
`ifdef SEQDET_AUTO_CLR_EN
      if (c == THR) begin
        c = inc ? 1 : 0;
        z = (c >= THR);
      end else if (inc) begin
        c = (c + 1 > maxv) ? maxv : c + 1;
        z = (c >= THR);
      end
`else
      if (inc) begin
        c = (c + 1 > maxv) ? maxv : c + 1;
        z = (c >= THR);
      end
`endif
    end
  endtask

  always @(posedge clk) begin
    bit inc;
    logic [3:0] w;
    inc = 0;
    if (rst) begin
      m_pat = PAT_RST_DEF;
      m_bits.delete();
      m_z1 = 0;
      m_cnt_a = 0; m_z2_a = 0;
      m_cnt_b = 0; m_z2_b = 0;
    end else begin
      if (pat_ld) begin
        m_pat = pat;
        m_bits.delete();
        m_z1 = 0;
      end else if (x_vld) begin
        m_bits.push_back(x);
        if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
        if (m_bits.size() == PAT_LEN) begin
          w = 4'b0;
          foreach (m_bits[i]) w = {w[2:0], m_bits[i]};
          inc = (w == m_pat);
        end
        if (inc && !ovl) m_bits.delete();
        m_z1 = inc;
      end else begin
        m_z1 = 0;
      end
      cnt_model(m_cnt_a, m_z2_a, MAX_A, inc, clr);
      cnt_model(m_cnt_b, m_z2_b, MAX_B, inc, clr);
    end
    m_valid = 1;
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("z1_a",  32'(z1_a),  32'(m_z1));
      check("z2_a",  32'(z2_a),  32'(m_z2_a));
      check("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      check("z1_b",  32'(z1_b),  32'(m_z1));
      check("z2_b",  32'(z2_b),  32'(m_z2_b));
      check("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
    end
  end

  // driver tasks
  task automatic step(input logic s_rst, input logic s_x, input logic s_vld, input logic s_ld,
                      input logic [3:0] s_pat, input logic s_clr);
    rst = s_rst; x = s_x; x_vld = s_vld; pat_ld = s_ld; pat = s_pat; clr = s_clr;
    @(posedge clk);
    @(negedge clk);
    z1_log = {z1_log[14:0], z1_a};
  endtask

  task automatic send(input logic b);
    step(1'b0, b, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic gap();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    check("rst_z1",  32'(z1_a),  32'd0);
    check("rst_z2",  32'(z2_a),  32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    z1_log = '0;
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; x_vld = 1'b0; pat_ld = 1'b0; pat = 4'b0; ovl = 1'b1; clr = 1'b0;
    z1_log = '0;

    // overlapping 1001001: two hits
    do_reset();
    ovl = 1'b1;
    send_bits(16'b1001001, 7);
    check("t1_z1_seq", 32'(z1_log[6:0]), 32'b0001001);
    check("t1_cnt", 32'(cnt_a), 32'd2);
    check("t1_z2",  32'(z2_a),  32'd0);

    // non-overlapping: one hit
    do_reset();
    ovl = 1'b0;
    send_bits(16'b1001001, 7);
    check("t2_z1_seq", 32'(z1_log[6:0]), 32'b0001000);
    check("t2_cnt", 32'(cnt_a), 32'd1);

    // valid gaps
    do_reset();
    ovl = 1'b1;
    send(1'b1); gap(); send(1'b0); send(1'b0); gap(); gap(); send(1'b1);
    check("t3_z1_seq", 32'(z1_log[6:0]), 32'b0000001);
    check("t3_cnt", 32'(cnt_a), 32'd1);

    // pattern load mid-stream drops the coincident bit and old history
    do_reset();
    send_bits(16'b100, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    send_bits(16'b0110, 4);
    check("t4_z1_seq", 32'(z1_log[7:0]), 32'b00000001);
    check("t4_cnt", 32'(cnt_a), 32'd1);

    // threshold at three matches
    do_reset();
    ovl = 1'b1;
    send_bits(16'b1001001001, 10);
    check("t5_cnt_a", 32'(cnt_a), 32'd3);
    check("t5_z2_a",  32'(z2_a),  32'd1);
    check("t5_cnt_b", 32'(cnt_b), 32'd3);
    check("t5_z2_b",  32'(z2_b),  32'd1);
`ifdef SEQDET_AUTO_CLR_EN
    send(1'b0);
    check("t5_auto_cnt", 32'(cnt_a), 32'd0);
    check("t5_auto_z2",  32'(z2_a),  32'd0);
`else
    send_bits(16'b001, 3);
    check("t5_cnt4_a", 32'(cnt_a), 32'd4);
    check("t5_z2_sticky", 32'(z2_a), 32'd1);
    check("t5_sat_b", 32'(cnt_b), 32'd3);
`endif

    // saturation on the narrow counter, then CLR racing a match
    do_reset();
    ovl = 1'b1;
    send(1'b1);
    for (int k = 0; k < 5; k++) send_bits(16'b001, 3);
`ifndef SEQDET_AUTO_CLR_EN
    check("t6_sat_b", 32'(cnt_b), 32'd3);
    check("t6_cnt_a", 32'(cnt_a), 32'd5);
`endif
    send(1'b0); send(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("t6_clr_z1",  32'(z1_a),  32'd1);
    check("t6_clr_cnt", 32'(cnt_a), 32'd0);
    check("t6_clr_z2",  32'(z2_a),  32'd0);
    check("t6_clr_cnt_b", 32'(cnt_b), 32'd0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] np;
      case ($urandom_range(0, 3))
        0:       np = 4'b1111;
        1:       np = 4'b1010;
        2:       np = 4'b1001;
        default: np = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 29) == 0) ovl = ~ovl;
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 39) == 0), np,
           1'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
